// File: rtl/spi_pkg.sv
// Shared definitions for the SPI frame master: state encoding and default timing.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LOAD  = 3'd2,
    LO    = 3'd3,
    HI    = 3'd4,
    HOLD  = 3'd5,
    GAP   = 3'd6
  } state_e;

  localparam int unsigned DEF_DIV      = 8;
  localparam int unsigned DEF_CS_SETUP = 4;
  localparam int unsigned DEF_CS_HOLD  = 4;
  localparam int unsigned DEF_CS_GAP   = 8;

  // Standard CNC stepper frame length in bytes.
  localparam int unsigned FRAME_BYTES  = 20;

endpackage

// File: rtl/spi_phase_timer.sv
// Loadable 8-bit down-counter; tc_o is high in the last cycle of a timed phase.
module spi_phase_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic       tc_o
);

  logic [7:0] cnt_q, cnt_d;

  // Reload on a phase change, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)            cnt_d = load_val_i;
    else if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
  end

  // Counter register.
  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == 8'd0);

endmodule

// File: rtl/spi_frame_master.sv
// SPI mode-0 frame master: streams frame_len bytes out on MOSI while collecting MISO.
module spi_frame_master
  import spi_pkg::*;
#(
  parameter int unsigned DIV      = DEF_DIV,
  parameter int unsigned CS_SETUP = DEF_CS_SETUP,
  parameter int unsigned CS_HOLD  = DEF_CS_HOLD,
  parameter int unsigned CS_GAP   = DEF_CS_GAP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [4:0] frame_len,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       done,
  output logic       SCK,
  output logic       MOSI,
  input  logic       MISO,
  output logic       SSEL
);

  state_e     state_q, state_d;
  logic       ssel_q, ssel_d;
  logic       sck_q, sck_d;
  logic       mosi_q, mosi_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [2:0] bit_q, bit_d;
  logic [4:0] bytes_left_q, bytes_left_d;
  logic       miso_meta_q, miso_s_q;
  logic       phase_load, phase_tc;
  logic [7:0] phase_len;

  // Length of the phase being entered, minus one, so the timer expires on its last cycle.
  always_comb begin
    phase_len = 8'd0;
    case (state_d)
      SETUP:   phase_len = 8'(CS_SETUP - 1);
      LO, HI:  phase_len = 8'(DIV - 1);
      HOLD:    phase_len = 8'(CS_HOLD - 1);
      GAP:     phase_len = 8'(CS_GAP - 1);
      default: phase_len = 8'd0;
    endcase
  end

  assign phase_load = (state_d != state_q);

  spi_phase_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (phase_load),
    .load_val_i (phase_len),
    .tc_o       (phase_tc)
  );

  // Next-state and datapath decode; pin values are computed here and registered below.
  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    ssel_d       = ssel_q;
    sck_d        = sck_q;
    mosi_d       = mosi_q;
    tx_shift_d   = tx_shift_q;
    rx_shift_d   = rx_shift_q;
    bit_d        = bit_q;
    bytes_left_d = bytes_left_q;
    tx_ready     = 1'b0;
    rx_valid     = 1'b0;
    done         = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && frame_len != 5'd0) begin
          bytes_left_d = frame_len;
          ssel_d       = 1'b0;
          state_d      = SETUP;
        end
      end
      SETUP: if (phase_tc) state_d = LOAD;
      LOAD: begin
        tx_ready = 1'b1;
        sck_d    = 1'b0;
        if (tx_valid) begin
          tx_shift_d = tx_data;
          mosi_d     = tx_data[7];
          bit_d      = 3'd0;
          state_d    = LO;
        end
      end
      LO: begin
        if (phase_tc) begin
          sck_d   = 1'b1;
          state_d = HI;
        end
      end
      HI: begin
        if (phase_tc) begin
          sck_d      = 1'b0;
          rx_shift_d = {rx_shift_q[6:0], miso_s_q};
          if (bit_q != 3'd7) begin
            // Next MOSI bit launches on the same edge that drops SCK.
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
            mosi_d     = tx_shift_q[6];
            bit_d      = bit_q + 3'd1;
            state_d    = LO;
          end else begin
            rx_valid     = 1'b1;
            bytes_left_d = bytes_left_q - 5'd1;
            state_d      = (bytes_left_q == 5'd1) ? HOLD : LOAD;
          end
        end
      end
      HOLD: begin
        if (phase_tc) begin
          ssel_d  = 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
        if (phase_tc) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pin and shift registers; async reset forces the bus idle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ssel_q       <= 1'b1;
      sck_q        <= 1'b0;
      mosi_q       <= 1'b0;
      tx_shift_q   <= 8'd0;
      rx_shift_q   <= 8'd0;
      bit_q        <= 3'd0;
      bytes_left_q <= 5'd0;
    end else begin
      state_q      <= state_d;
      ssel_q       <= ssel_d;
      sck_q        <= sck_d;
      mosi_q       <= mosi_d;
      tx_shift_q   <= tx_shift_d;
      rx_shift_q   <= rx_shift_d;
      bit_q        <= bit_d;
      bytes_left_q <= bytes_left_d;
    end
  end

  // Two-flop synchronizer for the asynchronous MISO pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_meta_q <= 1'b0;
      miso_s_q    <= 1'b0;
    end else begin
      miso_meta_q <= MISO;
      miso_s_q    <= miso_meta_q;
    end
  end

  // The received byte is complete in the last HI cycle of bit 7, when rx_valid pulses.
  assign rx_data = {rx_shift_q[6:0], miso_s_q};
  assign busy    = (state_q != IDLE);
  assign SSEL    = ssel_q;
  assign SCK     = sck_q;
  assign MOSI    = mosi_q;

endmodule

// File: tb/tb_spi_frame_master.sv
// Directed bench for spi_frame_master: loopback, slave model, stall, reset, ignored starts.
module tb_spi_frame_master;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [4:0] frame_len = 5'd0;
  logic [7:0] tx_data = 8'd0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, rx_valid, busy, done, SCK, MOSI, MISO, SSEL;
  logic [7:0] rx_data;
  logic       use_slave = 1'b0;
  logic       slave_miso = 1'b0;

  assign MISO = use_slave ? slave_miso : MOSI;

  spi_frame_master #(.DIV(DIV), .CS_SETUP(4), .CS_HOLD(4), .CS_GAP(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_len(frame_len),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done),
    .SCK(SCK), .MOSI(MOSI), .MISO(MISO), .SSEL(SSEL)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int rx_cnt = 0, done_cnt = 0, hs_cnt = 0, ssel_low = 0, mosi_high = 0, mosi_bad = 0;
  int rises = 0, high_ok = 0, high_bad = 0, low_ok = 0, run = 0;
  int stall_sck_bad = 0, stall_ssel_bad = 0;
  logic       prev_sck = 1'b0, prev_mosi = 1'b0;
  logic [7:0] mosi_bits = 8'd0;
  logic [7:0] rx_q[$];
  logic [7:0] cap_q[$];

  // Pin monitor, sampled on the falling clk edge.
  always @(negedge clk) begin
    if (rx_valid) begin rx_q.push_back(rx_data); rx_cnt++; end
    if (done) done_cnt++;
    if (!SSEL) ssel_low++;
    if (!SSEL && MOSI) mosi_high++;
    if (MOSI !== prev_mosi && SCK === 1'b1) mosi_bad++;
    if (SCK === prev_sck) run++;
    else begin
      if (prev_sck) begin
        if (run == DIV) high_ok++; else high_bad++;
      end else begin
        rises++;
        mosi_bits = {mosi_bits[6:0], MOSI};
        if (run == DIV) low_ok++;
      end
      run = 1;
    end
    prev_sck  = SCK;
    prev_mosi = MOSI;
  end

  // Handshakes are counted at the edge that consumes them.
  always @(posedge clk) if (tx_ready && tx_valid) hs_cnt++;

  // Behavioural mode-0 slave: returns byte index 0,1,2,... and captures MOSI.
  logic [7:0] s_tx = 8'd0, s_rx = 8'd0;
  int         s_bit = 0, s_byte = 0;
  logic       s_pend = 1'b0;
  always @(negedge SSEL) begin
    s_bit = 0; s_byte = 0; s_tx = 8'h00; s_pend = 1'b0; slave_miso = s_tx[7];
  end
  always @(posedge SCK) if (!SSEL) begin
    s_rx = {s_rx[6:0], MOSI};
    s_bit++;
    if (s_bit == 8) begin
      cap_q.push_back(s_rx);
      s_bit = 0; s_byte++; s_tx = 8'(s_byte); s_pend = 1'b1;
    end
  end
  always @(negedge SCK) if (!SSEL) begin
    if (s_pend) s_pend = 1'b0;
    else        s_tx = {s_tx[6:0], 1'b0};
    slave_miso = s_tx[7];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [4:0] len);
    frame_len = len;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int to = 0;
    while (!tx_ready && to < 3000) begin tick(); to++; end
    check(tag, (to < 3000), 1'b1);
  endtask

  // Feeds n bytes base, base+1, ...; optionally withholds tx_valid 50 cycles before stall_idx.
  task automatic send_bytes(input int n, input logic [7:0] base, input int stall_idx);
    for (int b = 0; b < n; b++) begin
      if (b == stall_idx) begin
        wait_ready("stall_reach_load");
        repeat (50) begin
          tick();
          if (SCK !== 1'b0) stall_sck_bad++;
          if (SSEL !== 1'b0) stall_ssel_bad++;
        end
      end
      tx_data  = base + 8'(b);
      tx_valid = 1'b1;
      wait_ready("tx_ready_timeout");
      tick();
      tx_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag, input int prev);
    int to = 0;
    while (done_cnt == prev && to < 5000) begin tick(); to++; end
    check(tag, done_cnt, prev + 1);
  endtask

  initial begin
    int d0, r0, h0, s0, rs0, hi0, hb0, lo0, mb0, mh0, b0, errs;
    #200_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, r0, h0, s0, rs0, hi0, hb0, lo0, mb0, mh0, b0, errs;
    // Reset values.
    repeat (3) tick();
    check("rst_ssel", SSEL, 1'b1);
    check("rst_sck", SCK, 1'b0);
    check("rst_mosi", MOSI, 1'b0);
    check("rst_tx_ready", tx_ready, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    rst_n = 1'b1;
    repeat (3) tick();

    // Loopback, one byte 0xA5.
    d0 = done_cnt; r0 = rx_cnt; h0 = hs_cnt; s0 = ssel_low; rs0 = rises;
    hi0 = high_ok; hb0 = high_bad; lo0 = low_ok; mb0 = mosi_bad; b0 = rx_q.size();
    start_frame(5'd1);
    check("lb_busy", busy, 1'b1);
    send_bytes(1, 8'hA5, -1);
    wait_done("lb_done", d0);
    check("lb_rx_count", rx_cnt - r0, 1);
    check("lb_rx_data", rx_q[b0], 8'hA5);
    check("lb_sck_pulses", rises - rs0, 8);
    check("lb_high_4", high_ok - hi0, 8);
    check("lb_high_bad", high_bad - hb0, 0);
    check("lb_low_4", low_ok - lo0, 7);
    check("lb_ssel_low", ssel_low - s0, 4 + 65 + 4);
    check("lb_handshakes", hs_cnt - h0, 1);
    check("lb_mosi_edge", mosi_bad - mb0, 0);
    tick();
    check("lb_idle_busy", busy, 1'b0);

    // Slave model, 20-byte frame.
    use_slave = 1'b1;
    cap_q.delete();
    d0 = done_cnt; r0 = rx_cnt; h0 = hs_cnt; s0 = ssel_low; b0 = rx_q.size();
    start_frame(5'd20);
    send_bytes(20, 8'h10, -1);
    wait_done("sl_done", d0);
    check("sl_rx_count", rx_cnt - r0, 20);
    errs = 0;
    for (int i = 0; i < 20; i++) if (rx_q[b0 + i] !== 8'(i)) errs++;
    check("sl_rx_stream", errs, 0);
    check("sl_cap_count", cap_q.size(), 20);
    errs = 0;
    for (int i = 0; i < 20; i++) if (cap_q[i] !== 8'(8'h10 + i)) errs++;
    check("sl_cap_stream", errs, 0);
    check("sl_handshakes", hs_cnt - h0, 20);
    check("sl_ssel_low", ssel_low - s0, 4 + 20 * 65 + 4);
    use_slave = 1'b0;
    repeat (3) tick();

    // Underflow stall before byte 3 of 4.
    d0 = done_cnt; r0 = rx_cnt; h0 = hs_cnt; b0 = rx_q.size();
    start_frame(5'd4);
    send_bytes(4, 8'h41, 2);
    wait_done("uf_done", d0);
    check("uf_sck_stall", stall_sck_bad, 0);
    check("uf_ssel_stall", stall_ssel_bad, 0);
    check("uf_rx_count", rx_cnt - r0, 4);
    errs = 0;
    for (int i = 0; i < 4; i++) if (rx_q[b0 + i] !== 8'(8'h41 + i)) errs++;
    check("uf_rx_stream", errs, 0);
    check("uf_handshakes", hs_cnt - h0, 4);
    repeat (3) tick();

    // MSB and launch-edge check with 0x80.
    d0 = done_cnt; mh0 = mosi_high; mb0 = mosi_bad; b0 = rx_q.size();
    start_frame(5'd1);
    send_bytes(1, 8'h80, -1);
    wait_done("msb_done", d0);
    check("msb_bits", mosi_bits, 8'h80);
    check("msb_high_cycles", mosi_high - mh0, 2 * DIV);
    check("msb_edge", mosi_bad - mb0, 0);
    check("msb_rx", rx_q[b0], 8'h80);
    repeat (3) tick();

    // Reset during bit 4 of byte 0.
    d0 = done_cnt; r0 = rx_cnt; rs0 = rises;
    start_frame(5'd1);
    send_bytes(1, 8'h5A, -1);
    begin
      int to = 0;
      while (rises - rs0 < 5 && to < 500) begin tick(); to++; end
    end
    check("rst_reach_bit4", rises - rs0, 5);
    check("rst_pre_sck", SCK, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ssel", SSEL, 1'b1);
    check("rst_mid_sck", SCK, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    repeat (5) tick();
    check("rst_mid_no_rx", rx_cnt - r0, 0);
    check("rst_mid_no_done", done_cnt - d0, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    d0 = done_cnt; b0 = rx_q.size();
    start_frame(5'd1);
    send_bytes(1, 8'h3C, -1);
    wait_done("rst_new_done", d0);
    check("rst_new_rx", rx_q[b0], 8'h3C);
    repeat (3) tick();

    // Start while busy is ignored.
    d0 = done_cnt; r0 = rx_cnt; b0 = rx_q.size();
    start_frame(5'd1);
    send_bytes(1, 8'h11, -1);
    start_frame(5'd3);
    wait_done("ign_done", d0);
    s0 = ssel_low;
    repeat (50) tick();
    check("ign_busy_ssel", ssel_low - s0, 0);
    check("ign_busy_done", done_cnt - d0, 1);
    check("ign_busy_rx", rx_cnt - r0, 1);
    check("ign_busy_data", rx_q[b0], 8'h11);

    // Start with frame_len 0 is ignored.
    d0 = done_cnt; s0 = ssel_low;
    start_frame(5'd0);
    check("ign_zero_busy", busy, 1'b0);
    repeat (50) tick();
    check("ign_zero_ssel", ssel_low - s0, 0);
    check("ign_zero_done", done_cnt - d0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
